// File: rtl/blk_1683b2.sv
// blk_1683b2 -- instruction fetch (IF) stage.
// Holds the fetch PC and its valid flag. It presents {ce, pc} to ID and drives the
// instruction SRAM read port. Instruction data comes back one cycle later.
// Optional feature: define IF_BR_HOLD_EN to build the pending-redirect buffer.
// With the buffer, a branch that arrives while the PC stage is stalled is saved
// and taken on the first unstalled cycle. Without it, such a branch is dropped.
// Both builds have the same port list.
//
// state | meaning                         (IF_BR_HOLD_EN builds only)
// RUN   | no redirect pending
// HOLD  | redirect captured during a stall, waiting for release
module blk_1683b2 (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  stall,
  input  logic [32:0] br_bus,
  output logic [32:0] if_to_id_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata
);

  localparam logic        STOP     = 1'b1;
  // One word below the boot vector, so the first increment fetches 0xBFC0_0000.
  localparam logic [31:0] PC_RESET = 32'hBFBF_FFFC;

  logic        br_e;
  logic [31:0] br_addr;
  logic        pc_stop;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        ce_q;

  // stall[1] freezes the IF/ID register, which lives in the ID stage.
  logic        unused_stall;

  assign br_e         = br_bus[32];
  assign br_addr      = br_bus[31:0];
  assign pc_stop      = (stall[0] == STOP);
  assign unused_stall = stall[1];

`ifdef IF_BR_HOLD_EN
  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  state_t      state_q;
  logic [31:0] pend_addr_q;
  logic        pend_v;

  assign pend_v = (state_q == HOLD);

  // Next fetch address: live redirect first, then the buffered one, then sequential.
  always_comb begin
    pc_d = pc_q + 32'h4;
    if (br_e) begin
      pc_d = br_addr;
    end else if (pend_v) begin
      pc_d = pend_addr_q;
    end
  end

  // PC register and RUN/HOLD redirect buffer. The newest redirect in a stall wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= PC_RESET;
      ce_q        <= 1'b0;
      state_q     <= RUN;
      pend_addr_q <= 32'h0;
    end else if (!pc_stop) begin
      pc_q    <= pc_d;
      ce_q    <= 1'b1;
      state_q <= RUN;
    end else if (br_e) begin
      state_q     <= HOLD;
      pend_addr_q <= br_addr;
    end
  end
`else
  // Next fetch address: live redirect, else sequential.
  always_comb begin
    pc_d = br_e ? br_addr : (pc_q + 32'h4);
  end

  // PC register. A redirect that arrives during a stall is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= PC_RESET;
      ce_q <= 1'b0;
    end else if (!pc_stop) begin
      pc_q <= pc_d;
      ce_q <= 1'b1;
    end
  end
`endif

  assign if_to_id_bus    = {ce_q, pc_q};
  assign inst_sram_en    = ce_q;
  assign inst_sram_addr  = pc_q;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_wdata = 32'h0;

endmodule

// File: tb/tb_blk_1683b2.sv
// Testbench for blk_1683b2 (fetch stage).
// A driver applies stimulus and pushes the expected {ce, pc} into a queue.
// A monitor pops one entry after every rising edge and compares it with the DUT.
module tb_blk_1683b2;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  stall;
  logic [32:0] br_bus;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;

  blk_1683b2 dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .br_bus          (br_bus),
    .if_to_id_bus    (if_to_id_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata)
  );

  always #5 clk = ~clk;

  // Reference state. These are the architectural quantities, not the RTL encoding.
  logic [31:0] m_pc;
  logic        m_ce;
  logic        m_pend;
  logic [31:0] m_pend_addr;

  logic [32:0] exp_q[$];
  string       tag_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  bit          stim_done = 1'b0;

  // Apply one cycle of inputs. Advance the model across the coming edge and queue the result.
  task automatic step(input bit r, input bit stp, input bit be, input logic [31:0] ba,
                      input string tag);
    rst    = r;
    stall  = {1'b0, stp};
    br_bus = {be, ba};
    if (r) begin
      m_pc = 32'hBFBF_FFFC; m_ce = 1'b0; m_pend = 1'b0; m_pend_addr = 32'h0;
    end else if (!stp) begin
      if (be)          m_pc = ba;
      else if (m_pend) m_pc = m_pend_addr;
      else             m_pc = m_pc + 32'h4;
      m_ce   = 1'b1;
      m_pend = 1'b0;
    end else begin
`ifdef IF_BR_HOLD_EN
      if (be) begin
        m_pend      = 1'b1;
        m_pend_addr = ba;
      end
`endif
    end
    exp_q.push_back({m_ce, m_pc});
    tag_q.push_back(tag);
    @(negedge clk);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, tag);
  endtask

  task automatic do_reset(input string tag);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0, tag);
  endtask

  // Monitor: compare every output against the oldest queued expectation.
  initial begin
    logic [32:0] e;
    string       t;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        vectors++;
        if (if_to_id_bus !== e || inst_sram_en !== e[32] || inst_sram_addr !== e[31:0] ||
            inst_sram_wen !== 4'b0000 || inst_sram_wdata !== 32'h0) begin
          miscompares++;
          $display("FAIL %s: got bus=%h en=%b addr=%h wen=%h wdata=%h, want bus=%h en=%b addr=%h wen=0 wdata=0",
                   t, if_to_id_bus, inst_sram_en, inst_sram_addr, inst_sram_wen,
                   inst_sram_wdata, e, e[32], e[31:0]);
        end
      end
    end
  end

  initial begin
    logic [31:0] ra;
    rst = 1'b1; stall = 2'b00; br_bus = 33'h0;
    m_pc = 32'h0; m_ce = 1'b0; m_pend = 1'b0; m_pend_addr = 32'h0;

    // Reset state, then sequential fetch 0xBFC00000/04/08, then a branch taken at 0xBFC00008.
    do_reset("reset_state");
    run(3, "seq_after_reset");
    step(1'b0, 1'b0, 1'b1, 32'hBFC0_0100, "branch_unstalled");
    run(2, "seq_after_branch");

    // A 3-cycle stall at 0xBFC00010 with no branch.
    do_reset("reset2");
    run(5, "to_0010");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'hDEAD_BEE0, "stall_hold");
    run(2, "stall_release");

    // A branch in stall cycle 1 only. It is buffered with the macro and dropped without it.
    do_reset("reset3");
    run(5, "to_0010b");
    step(1'b0, 1'b1, 1'b1, 32'hBFC0_0200, "stall_br");
    step(1'b0, 1'b1, 1'b0, 32'h1234_5670, "stall_nobr");
    step(1'b0, 1'b1, 1'b0, 32'h0, "stall_nobr");
    run(2, "release_pending");

    // Two branches in one stall: the newest wins.
    step(1'b0, 1'b1, 1'b1, 32'hBFC0_0300, "two_br_a");
    step(1'b0, 1'b1, 1'b1, 32'hBFC0_0400, "two_br_b");
    run(2, "two_br_release");

    // A live branch on the release cycle beats the pending one.
    step(1'b0, 1'b1, 1'b1, 32'hBFC0_0300, "live_pend");
    step(1'b0, 1'b0, 1'b1, 32'hBFC0_0500, "live_beats_pend");
    run(1, "live_after");

    // Reset during a buffered stall: the pending target is discarded.
    step(1'b0, 1'b1, 1'b1, 32'hBFC0_0700, "pend_before_rst");
    step(1'b1, 1'b1, 1'b1, 32'hBFC0_0800, "rst_mid_hold");
    step(1'b1, 1'b0, 1'b0, 32'h0, "rst_mid_hold2");
    step(1'b0, 1'b1, 1'b0, 32'h0, "post_rst_stall");
    run(2, "post_rst_fetch");

    // The address wraps from 0xFFFFFFFC to 0.
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, "br_to_top");
    run(2, "wrap");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      ra = $urandom() & 32'hFFFF_FFFC;
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 35),
           ($urandom_range(0, 99) < 20), ra, "random");
    end
    stall = 2'b00; br_bus = 33'h0; rst = 1'b0;

    // Bounded wait for the monitor to drain the queue.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    stim_done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
